// File: rtl/regfile_sp_param_pkg.sv
// Shared definitions for the parametrised register file: default sizes,
// a constant-foldable clog2 and the stack-pointer operation encoding.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_NUM_RD   = 2;

    // Outcome of the per-cycle SP priority decode.
    typedef enum logic [1:0] {
        SP_NONE,
        SP_WRITE,
        SP_DEC,
        SP_INC
    } sp_op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_sp_param_if.sv
// Bus bundle between the decode/writeback stages (master) and the register file (slave).
interface regfile_sp_param_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
);
    localparam int AW = clog2(NUM_REGS);

    logic                     WE;
    logic [AW-1:0]            RW_addr;
    logic [DATA_W-1:0]        WD;
    logic                     IncSP;
    logic                     DecSP;
    logic                     ClrErr;
    logic [NUM_RD*AW-1:0]     RA_addr;
    logic [NUM_RD*DATA_W-1:0] RD;
    logic [DATA_W-1:0]        SP;
    logic                     SP_ovf;
    logic                     SP_unf;

    modport master (
        output WE, RW_addr, WD, IncSP, DecSP, ClrErr, RA_addr,
        input  RD, SP, SP_ovf, SP_unf
    );

    modport slave (
        input  WE, RW_addr, WD, IncSP, DecSP, ClrErr, RA_addr,
        output RD, SP, SP_ovf, SP_unf
    );

endinterface

// File: rtl/regfile_sp_param_sp_unit.sv
// Stack-pointer control: priority decode, saturating inc/dec and the sticky
// overflow/underflow flags. The SP register itself lives in the top-level array.
module sp_unit
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SP_TOP    = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_BOTTOM = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_sp_sel,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [DATA_W-1:0] i_sp,
    output logic [DATA_W-1:0] o_sp_next,
    output logic              o_ovf,
    output logic              o_unf
);

    sp_op_e w_op;
    logic   w_set_ovf;
    logic   w_set_unf;
    logic   r_ovf;
    logic   r_unf;

    // An explicit write to SP masks both stack requests; DEC beats INC.
    always_comb begin
        w_op = SP_NONE;
        if (i_we && i_sp_sel) begin
            w_op = SP_WRITE;
        end else if (i_dec) begin
            w_op = SP_DEC;
        end else if (i_inc) begin
            w_op = SP_INC;
        end
    end

    always_comb begin
        o_sp_next = i_sp;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        unique case (w_op)
            SP_WRITE: o_sp_next = i_wd;
            SP_DEC: begin
                if (i_sp == SP_BOTTOM) w_set_ovf = 1'b1;
                else                   o_sp_next = i_sp - DATA_W'(1);
            end
            SP_INC: begin
                if (i_sp == SP_TOP) w_set_unf = 1'b1;
                else                o_sp_next = i_sp + DATA_W'(1);
            end
            default: ;
        endcase
    end

    // A fault in the same cycle as ClrErr must survive the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~i_clr);
            r_unf <= w_set_unf | (r_unf & ~i_clr);
        end
    end

    assign o_ovf = r_ovf;
    assign o_unf = r_unf;

endmodule

// File: rtl/regfile_sp_param.sv
// Parametrised register file with combinational write-through reads and one
// register acting as a bounded hardware stack pointer.
module regfile_sp_param
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                NUM_REGS  = DEF_NUM_REGS,
    parameter int                NUM_RD    = DEF_NUM_RD,
    parameter int                SP_IDX    = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_TOP    = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_BOTTOM = '0
) (
    input  logic              clk,
    input  logic              rst,
    regfile_sp_param_if.slave bus
);

    localparam int AW = clog2(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_sp_next;
    logic              w_sp_sel;

    assign w_sp_sel = (bus.RW_addr == AW'(SP_IDX));

    sp_unit #(
        .DATA_W    (DATA_W),
        .SP_TOP    (SP_TOP),
        .SP_BOTTOM (SP_BOTTOM)
    ) u_sp_unit (
        .clk       (clk),
        .rst       (rst),
        .i_we      (bus.WE),
        .i_sp_sel  (w_sp_sel),
        .i_inc     (bus.IncSP),
        .i_dec     (bus.DecSP),
        .i_clr     (bus.ClrErr),
        .i_wd      (bus.WD),
        .i_sp      (r_regs[SP_IDX]),
        .o_sp_next (w_sp_next),
        .o_ovf     (bus.SP_ovf),
        .o_unf     (bus.SP_unf)
    );

    // The SP slot always takes sp_unit's result, which already folds in an explicit write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_TOP : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_IDX) begin
                    r_regs[i] <= w_sp_next;
                end else if (bus.WE && (bus.RW_addr == AW'(i))) begin
                    r_regs[i] <= bus.WD;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] w_ra;
            assign w_ra = bus.RA_addr[gi*AW +: AW];
            assign bus.RD[gi*DATA_W +: DATA_W] =
                (bus.WE && (w_ra == bus.RW_addr)) ? bus.WD : r_regs[w_ra];
        end
    endgenerate

    assign bus.SP = r_regs[SP_IDX];

endmodule

// File: tb/tb_regfile_sp_param.sv
// Drives a default 8-bit instance and a 16-bit/8-register/3-port instance
// against an array-based reference model, plus directed literal scenarios.
module tb_regfile_sp_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Generic stimulus; index 0 = default instance, 1 = wide instance.
    logic        in_we  [2];
    logic [2:0]  in_rw  [2];
    logic [15:0] in_wd  [2];
    logic        in_inc [2];
    logic        in_dec [2];
    logic        in_clr [2];
    logic [2:0]  in_ra  [2][3];

    logic [15:0] m_reg [2][8];
    logic        m_ovf [2];
    logic        m_unf [2];

    regfile_sp_param_if #(.DATA_W(8),  .NUM_REGS(4), .NUM_RD(2)) bus_a ();
    regfile_sp_param_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) bus_b ();

    regfile_sp_param dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    regfile_sp_param #(
        .DATA_W    (16),
        .NUM_REGS  (8),
        .NUM_RD    (3),
        .SP_IDX    (7),
        .SP_BOTTOM (16'h0100)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_a.WE      = in_we[0];
    assign bus_a.RW_addr = in_rw[0][1:0];
    assign bus_a.WD      = in_wd[0][7:0];
    assign bus_a.IncSP   = in_inc[0];
    assign bus_a.DecSP   = in_dec[0];
    assign bus_a.ClrErr  = in_clr[0];
    assign bus_a.RA_addr = {in_ra[0][1][1:0], in_ra[0][0][1:0]};

    assign bus_b.WE      = in_we[1];
    assign bus_b.RW_addr = in_rw[1];
    assign bus_b.WD      = in_wd[1];
    assign bus_b.IncSP   = in_inc[1];
    assign bus_b.DecSP   = in_dec[1];
    assign bus_b.ClrErr  = in_clr[1];
    assign bus_b.RA_addr = {in_ra[1][2], in_ra[1][1], in_ra[1][0]};

    function automatic int nregs(input int k);  return (k == 0) ? 4 : 8; endfunction
    function automatic int nrd(input int k);    return (k == 0) ? 2 : 3; endfunction
    function automatic int spidx(input int k);  return (k == 0) ? 3 : 7; endfunction
    function automatic logic [15:0] top(input int k); return (k == 0) ? 16'h00FF : 16'hFFFF; endfunction
    function automatic logic [15:0] bot(input int k); return (k == 0) ? 16'h0000 : 16'h0100; endfunction

    // ---------------- reference model ----------------
    function automatic logic sp_written(input int k);
        return in_we[k] && (int'(in_rw[k]) == spidx(k));
    endfunction
    function automatic logic [15:0] model_sp(input int k);
        return m_reg[k][spidx(k)];
    endfunction
    function automatic logic sets_ovf(input int k);
        return !sp_written(k) && in_dec[k] && (model_sp(k) == bot(k));
    endfunction
    function automatic logic sets_unf(input int k);
        return !sp_written(k) && !in_dec[k] && in_inc[k] && (model_sp(k) == top(k));
    endfunction
    function automatic logic [15:0] stack_next(input int k);
        if (sp_written(k)) return in_wd[k] & top(k);
        if (in_dec[k])     return sets_ovf(k) ? model_sp(k) : model_sp(k) - 16'd1;
        if (in_inc[k])     return sets_unf(k) ? model_sp(k) : model_sp(k) + 16'd1;
        return model_sp(k);
    endfunction
    function automatic logic [15:0] model_rd(input int k, input int p);
        if (in_we[k] && (in_ra[k][p] == in_rw[k])) return in_wd[k] & top(k);
        return m_reg[k][in_ra[k][p]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 8; r++) m_reg[k][r] <= (r == spidx(k)) ? top(k) : 16'h0;
                m_ovf[k] <= 1'b0;
                m_unf[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (in_we[k]) m_reg[k][in_rw[k]] <= in_wd[k] & top(k);
                m_reg[k][spidx(k)] <= stack_next(k);
                m_ovf[k] <= sets_ovf(k) | (m_ovf[k] & ~in_clr[k]);
                m_unf[k] <= sets_unf(k) | (m_unf[k] & ~in_clr[k]);
            end
        end
    end

    // ---------------- DUT observation ----------------
    function automatic logic [15:0] act_rd(input int k, input int p);
        if (k == 0) return {8'h00, bus_a.RD[p*8 +: 8]};
        return bus_b.RD[p*16 +: 16];
    endfunction
    function automatic logic [15:0] act_sp(input int k);
        return (k == 0) ? {8'h00, bus_a.SP} : bus_b.SP;
    endfunction
    function automatic logic act_ovf(input int k);
        return (k == 0) ? bus_a.SP_ovf : bus_b.SP_ovf;
    endfunction
    function automatic logic act_unf(input int k);
        return (k == 0) ? bus_a.SP_unf : bus_b.SP_unf;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < nrd(k); p++) chk($sformatf("cmp_rd%0d_u%0d", p, k), act_rd(k, p), model_rd(k, p));
                chk($sformatf("cmp_sp_u%0d", k),  act_sp(k),          model_sp(k));
                chk($sformatf("cmp_ovf_u%0d", k), 16'(act_ovf(k)),    16'(m_ovf[k]));
                chk($sformatf("cmp_unf_u%0d", k), 16'(act_unf(k)),    16'(m_unf[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            in_we[k] = 0; in_rw[k] = 0; in_wd[k] = 0;
            in_inc[k] = 0; in_dec[k] = 0; in_clr[k] = 0;
            for (int p = 0; p < 3; p++) in_ra[k][p] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs(input int k);
        in_we[k]  = ($urandom_range(0, 3) == 0);
        in_rw[k]  = 3'($urandom_range(0, nregs(k) - 1));
        if ($urandom_range(0, 2) == 0) in_rw[k] = 3'(spidx(k));
        case ($urandom_range(0, 4))
            0:       in_wd[k] = bot(k);
            1:       in_wd[k] = bot(k) + 16'd1;
            2:       in_wd[k] = top(k);
            3:       in_wd[k] = top(k) - 16'd1;
            default: in_wd[k] = (16'($urandom) & top(k)) | bot(k);
        endcase
        in_inc[k] = ($urandom_range(0, 9) < 4);
        in_dec[k] = ($urandom_range(0, 9) < 4);
        in_clr[k] = ($urandom_range(0, 19) == 0);
        for (int p = 0; p < 3; p++) in_ra[k][p] = 3'($urandom_range(0, nregs(k) - 1));
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Reset asserted mid-cycle: state must clear without a clock edge.
        in_we[0] = 1; in_rw[0] = 0; in_wd[0] = 16'h11; tick();
        in_rw[0] = 1; in_wd[0] = 16'h22; tick();
        in_we[0] = 0; in_dec[0] = 1; tick();
        in_dec[0] = 0; in_ra[0][0] = 1; in_ra[0][1] = 3;
        #1;
        chk("pre_rst_rd0", act_rd(0, 0), 16'h0022);
        chk("pre_rst_sp", act_sp(0), 16'h00FE);
        #1 rst = 1'b1;
        #1;
        $display("txn reset asserted mid-cycle");
        chk("rst_rd_reg1", act_rd(0, 0), 16'h0000);
        chk("rst_rd_reg3", act_rd(0, 1), 16'h00FF);
        chk("rst_sp", act_sp(0), 16'h00FF);
        chk("rst_ovf", 16'(act_ovf(0)), 16'h0);
        chk("rst_unf", 16'(act_unf(0)), 16'h0);
        in_ra[0][0] = 0; in_ra[0][1] = 2;
        #1;
        chk("rst_rd_reg0", act_rd(0, 0), 16'h0000);
        chk("rst_rd_reg2", act_rd(0, 1), 16'h0000);
        #1 rst = 1'b0;
        idle();
        tick();

        // Write-through bypass, then registered value.
        in_we[0] = 1; in_rw[0] = 1; in_wd[0] = 16'h5A; in_ra[0][0] = 1;
        #1;
        $display("txn bypass write r1=5A");
        chk("bypass_same_cycle", act_rd(0, 0), 16'h005A);
        tick();
        in_we[0] = 0;
        #1;
        chk("bypass_after_edge", act_rd(0, 0), 16'h005A);

        // Push/pop with DEC-over-INC priority.
        in_dec[0] = 1; tick(); tick(); tick();
        $display("txn dec x3");
        chk("dec3_sp", act_sp(0), 16'h00FC);
        in_inc[0] = 1; tick();
        chk("incdec_sp", act_sp(0), 16'h00FB);
        in_dec[0] = 0; tick(); tick(); tick(); tick();
        $display("txn inc x4");
        chk("inc4_sp", act_sp(0), 16'h00FF);
        chk("inc4_unf", 16'(act_unf(0)), 16'h0);

        // Saturation at both bounds and clear behaviour.
        tick();
        $display("txn inc at top");
        chk("sat_top_sp", act_sp(0), 16'h00FF);
        chk("sat_top_unf", 16'(act_unf(0)), 16'h1);
        in_inc[0] = 0; in_clr[0] = 1; tick();
        chk("clr_unf", 16'(act_unf(0)), 16'h0);
        in_clr[0] = 0; in_we[0] = 1; in_rw[0] = 3; in_wd[0] = 16'h00; tick();
        chk("write_sp0", act_sp(0), 16'h0000);
        in_we[0] = 0; in_dec[0] = 1; tick();
        $display("txn dec at bottom");
        chk("sat_bot_sp", act_sp(0), 16'h0000);
        chk("sat_bot_ovf", 16'(act_ovf(0)), 16'h1);
        in_clr[0] = 1; tick();
        chk("clr_vs_set_ovf", 16'(act_ovf(0)), 16'h1);
        in_dec[0] = 0; tick();
        chk("clr_ovf", 16'(act_ovf(0)), 16'h0);

        // Explicit SP write beats a same-cycle DEC.
        in_clr[0] = 0; in_we[0] = 1; in_rw[0] = 3; in_wd[0] = 16'h80; in_dec[0] = 1; tick();
        $display("txn sp write collides with dec");
        chk("collide_sp", act_sp(0), 16'h0080);
        chk("collide_ovf", 16'(act_ovf(0)), 16'h0);
        chk("collide_unf", 16'(act_unf(0)), 16'h0);
        idle();

        // Wide instance: three ports and a raised stack bottom.
        in_we[1] = 1; in_rw[1] = 2; in_wd[1] = 16'h1234; tick();
        in_rw[1] = 5; in_wd[1] = 16'hBEEF; tick();
        in_we[1] = 0; in_ra[1][0] = 2; in_ra[1][1] = 5; in_ra[1][2] = 7;
        #1;
        $display("txn wide read 2/5/7");
        chk("wide_rd0", act_rd(1, 0), 16'h1234);
        chk("wide_rd1", act_rd(1, 1), 16'hBEEF);
        chk("wide_rd2", act_rd(1, 2), 16'hFFFF);
        in_we[1] = 1; in_rw[1] = 7; in_wd[1] = 16'h0101; tick();
        in_we[1] = 0; in_dec[1] = 1; tick();
        chk("wide_sp_bottom", act_sp(1), 16'h0100);
        tick();
        $display("txn wide dec at bottom");
        chk("wide_sp_hold", act_sp(1), 16'h0100);
        chk("wide_ovf", 16'(act_ovf(1)), 16'h1);
        idle();
        tick();

        // Randomised traffic on both instances, with one asynchronous reset.
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs(0);
            randomize_inputs(1);
            if (i == 1000) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            tick();
        end
        $display("txn random phase done");

        idle();
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
